// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multichannel PWM.
// Imported by the top and the per-channel compare stage.
package pwm_pkg;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: duty compare against the shared counter,
// polarity inversion and the registered output.
module pwm_channel_cmp
  import pwm_pkg::*;
#(
  parameter int   CNT_W = DEF_CNT_W,
  parameter logic POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  input  logic             force_off,
  output logic             pwm_out
);

  logic out_d;
  logic out_q;

  always_comb begin
    out_d = POL;
    if (!force_off) begin
      out_d = (cnt < duty) ^ POL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= POL;
    end else begin
      out_q <= out_d;
    end
  end

  assign pwm_out = out_q;

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: shared edge/center counter, double-buffered
// period/duty/mode configuration applied at period boundaries.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int                NUM_CH  = DEF_NUM_CH,
  parameter int                CNT_W   = DEF_CNT_W,
  parameter logic [NUM_CH-1:0] POL_INV = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    mode_center,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_duty,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick,
  output logic [CNT_W-1:0]        cnt_value
);

  localparam int DW = NUM_CH * CNT_W;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] sh_per_q, sh_per_d;
  logic [DW-1:0]    duty_q, duty_d;
  logic [DW-1:0]    sh_duty_q, sh_duty_d;
  pwm_dir_e         dir_q, dir_d;
  pwm_mode_e        mode_q, mode_d;
  pwm_mode_e        mode_in;
  logic             pending_q, pending_d;

  logic             per_zero;
  logic             idle;
  logic             center_eff;
  logic [CNT_W-1:0] last;
  logic             tick;
  logic             xfer;
  logic             apply;

  assign mode_in  = mode_center ? CENTER : EDGE;
  assign per_zero = (per_q == '0);
  assign idle     = !enable || per_zero;
  assign last     = per_q - CNT_W'(1);

  // Periods of 1 or 2 have no distinct down-count leg.
  assign center_eff = (mode_q == CENTER) && (per_q > CNT_W'(2));

  always_comb begin
    tick = 1'b0;
    if (!idle) begin
      if (center_eff) begin
        tick = (dir_q == DIR_DOWN) && (cnt_q == CNT_W'(1));
      end else begin
        tick = (cnt_q >= last);
      end
    end
  end

  assign xfer  = cfg_valid && !pending_q;
  assign apply = pending_q && (tick || idle);

  always_comb begin
    cnt_d     = cnt_q;
    per_d     = per_q;
    sh_per_d  = sh_per_q;
    duty_d    = duty_q;
    sh_duty_d = sh_duty_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    pending_d = pending_q;

    if (xfer) begin
      sh_per_d  = cfg_period;
      sh_duty_d = cfg_duty;
      pending_d = 1'b1;
    end

    if (apply) begin
      per_d     = sh_per_q;
      duty_d    = sh_duty_q;
      pending_d = 1'b0;
      cnt_d     = '0;
      dir_d     = DIR_UP;
      mode_d    = mode_in;
    end else if (idle || tick) begin
      cnt_d  = '0;
      dir_d  = DIR_UP;
      mode_d = mode_in;
    end else if (!center_eff) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= last) begin
        cnt_d = cnt_q - CNT_W'(1);
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      per_q     <= '0;
      sh_per_q  <= '0;
      duty_q    <= '0;
      sh_duty_q <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= EDGE;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      sh_per_q  <= sh_per_d;
      duty_q    <= duty_d;
      sh_duty_q <= sh_duty_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pwm_channel_cmp #(
        .CNT_W (CNT_W),
        .POL   (POL_INV[gi])
      ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt_q),
        .duty      (duty_q[gi*CNT_W +: CNT_W]),
        .force_off (idle),
        .pwm_out   (pwm_out[gi])
      );
    end
  endgenerate

  assign cfg_ready   = !pending_q;
  assign period_tick = tick;
  assign cnt_value   = cnt_q;

endmodule
